// File: rtl/dsel_apb_master_if.sv
// Command/response and APB3 signal bundle for dsel_apb_master.
// The master modport is the initiator's view; slave is the requester + APB target side.
interface dsel_apb_master_if #(
  parameter int unsigned APB_AWIDTH = 32,
  parameter int unsigned APB_DWIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_AWIDTH-1:0] cmd_addr;
  logic [APB_DWIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [APB_DWIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_AWIDTH-1:0] paddr;
  logic [APB_DWIDTH-1:0] pwdata;
  logic                  pready;
  logic [APB_DWIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/dsel_apb_master.sv
// Single-outstanding command/response to APB3 initiator with an ACCESS-phase
// wait-state timeout so a hung slave cannot stall the master.
module dsel_apb_master #(
  parameter int unsigned APB_AWIDTH = 32,
  parameter int unsigned APB_DWIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                pclk,
  input logic                rst,
  dsel_apb_master_if.master  bus
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic                  r_psel,       w_psel;
  logic                  r_penable,    w_penable;
  logic                  r_pwrite,     w_pwrite;
  logic [APB_AWIDTH-1:0] r_paddr,      w_paddr;
  logic [APB_DWIDTH-1:0] r_pwdata,     w_pwdata;
  logic                  r_rsp_valid,  w_rsp_valid;
  logic [APB_DWIDTH-1:0] r_rsp_rdata,  w_rsp_rdata;
  logic                  r_rsp_err,    w_rsp_err;
  logic                  r_rsp_timeout, w_rsp_timeout;
  logic [CW-1:0]         r_cnt,        w_cnt;

  // State and output registers; reset drops psel/penable asynchronously
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_psel        <= w_psel;
      r_penable     <= w_penable;
      r_pwrite      <= w_pwrite;
      r_paddr       <= w_paddr;
      r_pwdata      <= w_pwdata;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
      r_cnt         <= w_cnt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_psel        = r_psel;
    w_penable     = r_penable;
    w_pwrite      = r_pwrite;
    w_paddr       = r_paddr;
    w_pwdata      = r_pwdata;
    w_rsp_valid   = 1'b0;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_err     = r_rsp_err;
    w_rsp_timeout = r_rsp_timeout;
    w_cnt         = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_pwrite    = bus.cmd_write;
          w_paddr     = bus.cmd_addr;
          w_pwdata    = bus.cmd_wdata;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable   = 1'b1;
        w_cnt       = '0;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // pready wins over a coincident timeout
        if (bus.pready) begin
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = bus.pslverr;
          w_rsp_timeout = 1'b0;
          w_rsp_rdata   = r_pwrite ? '0 : bus.prdata;
          w_state_nxt   = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == LIMIT)) begin
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
          w_rsp_rdata   = '0;
          w_state_nxt   = S_IDLE;
        end else if (r_cnt != '1) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;

endmodule

// File: tb/tb_dsel_apb_master.sv
// Self-checking bench for dsel_apb_master: directed and randomized transfers
// against a transaction-level latency/response model.
module tb_dsel_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dsel_apb_master_if #(.APB_AWIDTH(AW), .APB_DWIDTH(DW)) bus ();

  dsel_apb_master #(.APB_AWIDTH(AW), .APB_DWIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cmd();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom();
    bus.cmd_wdata = $urandom();
  endtask

  // One transfer from an IDLE negedge; model: pready on ACCESS cycle waits+1
  // unless that exceeds TO, in which case the transfer times out after TO cycles.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input bit err, input bit gap);
    bit          tmo;
    int          acc;
    logic [31:0] exp_rd;
    tmo    = (TO != 0) && (waits >= int'(TO));
    acc    = tmo ? int'(TO) : waits + 1;
    exp_rd = (tmo || wr) ? 32'h0 : rdata;

    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(negedge pclk);
    check("setup_psel",    64'(bus.psel),      64'(1));
    check("setup_penable", 64'(bus.penable),   64'(0));
    check("setup_pwrite",  64'(bus.pwrite),    64'(wr));
    check("setup_paddr",   64'(bus.paddr),     64'(addr));
    check("setup_pwdata",  64'(bus.pwdata),    64'(wdata));
    check("setup_ready",   64'(bus.cmd_ready), 64'(0));
    check("setup_rspv",    64'(bus.rsp_valid), 64'(0));
    scramble_cmd();
    bus.pready  = 1'($urandom_range(0, 1));
    bus.prdata  = $urandom();
    bus.pslverr = 1'($urandom_range(0, 1));
    for (int k = 1; k <= acc; k++) begin
      @(negedge pclk);
      check("acc_psel",    64'(bus.psel),      64'(1));
      check("acc_penable", 64'(bus.penable),   64'(1));
      check("acc_paddr",   64'(bus.paddr),     64'(addr));
      check("acc_pwrite",  64'(bus.pwrite),    64'(wr));
      check("acc_pwdata",  64'(bus.pwdata),    64'(wdata));
      check("acc_rspv",    64'(bus.rsp_valid), 64'(0));
      check("acc_ready",   64'(bus.cmd_ready), 64'(0));
      scramble_cmd();
      bus.pready  = !tmo && (k == acc);
      bus.prdata  = bus.pready ? rdata : $urandom();
      bus.pslverr = bus.pready ? err : 1'($urandom_range(0, 1));
    end
    @(negedge pclk);
    check("rsp_valid",   64'(bus.rsp_valid),   64'(1));
    check("rsp_err",     64'(bus.rsp_err),     64'(tmo || err));
    check("rsp_timeout", 64'(bus.rsp_timeout), 64'(tmo));
    check("rsp_rdata",   64'(bus.rsp_rdata),   64'(exp_rd));
    check("rsp_psel",    64'(bus.psel),        64'(0));
    check("rsp_penable", 64'(bus.penable),     64'(0));
    check("rsp_ready",   64'(bus.cmd_ready),   64'(1));
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    if (gap) begin
      @(negedge pclk);
      check("hold_rspv",    64'(bus.rsp_valid),   64'(0));
      check("hold_err",     64'(bus.rsp_err),     64'(tmo || err));
      check("hold_timeout", 64'(bus.rsp_timeout), 64'(tmo));
      check("hold_rdata",   64'(bus.rsp_rdata),   64'(exp_rd));
      check("hold_psel",    64'(bus.psel),        64'(0));
    end
  endtask

  initial begin
    logic [31:0] base;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(negedge pclk);
    check("rst_psel",        64'(bus.psel),        64'(0));
    check("rst_penable",     64'(bus.penable),     64'(0));
    check("rst_pwrite",      64'(bus.pwrite),      64'(0));
    check("rst_paddr",       64'(bus.paddr),       64'(0));
    check("rst_pwdata",      64'(bus.pwdata),      64'(0));
    check("rst_cmd_ready",   64'(bus.cmd_ready),   64'(1));
    check("rst_rsp_valid",   64'(bus.rsp_valid),   64'(0));
    check("rst_rsp_rdata",   64'(bus.rsp_rdata),   64'(0));
    check("rst_rsp_err",     64'(bus.rsp_err),     64'(0));
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
    rst = 1'b0;
    @(negedge pclk);

    // Directed: zero-wait write, 2-wait read, slave error, timeout, late pready
    do_xfer(1'b1, 32'h0,        32'h3,        0,  32'h0,        1'b0, 1'b1);
    do_xfer(1'b0, 32'h0000_0104, 32'hFFFF_0000, 2,  32'h2,        1'b0, 1'b1);
    do_xfer(1'b0, 32'h0000_0200, 32'h0,        0,  32'hDEAD_BEEF, 1'b1, 1'b1);
    do_xfer(1'b0, 32'h0000_0300, 32'h0,        10, 32'h1234_5678, 1'b0, 1'b1);
    do_xfer(1'b0, 32'h0000_0304, 32'h0,        3,  32'hCAFE_0001, 1'b0, 1'b1);
    do_xfer(1'b1, 32'h0000_0308, 32'hA5A5_5A5A, 4,  32'h0,        1'b0, 1'b1);

    // Back-to-back: cmd_valid held for three commands, pready always high
    base = 32'h0000_1000;
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h55;
    bus.cmd_write = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      check("b2b_psel",  64'(bus.psel),      64'((i % 3) != 0));
      check("b2b_ready", 64'(bus.cmd_ready), 64'((i % 3) == 0));
      check("b2b_rspv",  64'(bus.rsp_valid), 64'(((i % 3) == 0) && (i > 0)));
      if ((i % 3) != 0)
        check("b2b_paddr", 64'(bus.paddr), 64'(base + 32'(i / 3)));
      if (((i % 3) == 0) && (i > 0))
        check("b2b_rdata", 64'(bus.rsp_rdata), 64'(32'h55));
      bus.cmd_valid = (i <= 6);
      if ((i % 3) == 0) bus.cmd_addr = base + 32'(i / 3);
      @(negedge pclk);
    end
    check("b2b_quiet", 64'(bus.psel), 64'(0));
    bus.pready = 1'b0;

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom(), $urandom(), int'($urandom_range(0, 6)),
              $urandom(), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset during ACCESS: immediate psel/penable drop, no response
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge pclk);
    check("mid_penable", 64'(bus.penable), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_psel",    64'(bus.psel),      64'(0));
    check("mid_rst_penable", 64'(bus.penable),   64'(0));
    check("mid_rst_ready",   64'(bus.cmd_ready), 64'(1));
    @(negedge pclk);
    check("mid_rst_rspv", 64'(bus.rsp_valid), 64'(0));
    rst = 1'b0;
    @(negedge pclk);
    check("post_rst_rspv", 64'(bus.rsp_valid), 64'(0));
    check("post_rst_psel", 64'(bus.psel),      64'(0));
    do_xfer(1'b0, 32'h0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
